// File: rtl/eth_pkg.sv
// Shared Ethernet transmit definitions used by the frame builder and the MII transmit FSM.
package eth_pkg;

  localparam int C_HEADER_BYTES    = 14;
  localparam int C_MIN_PKT_BYTES   = 46;
  localparam int C_MIN_FRAME_BYTES = 60;
  localparam logic [47:0] C_BROADCAST = 48'hFFFFFFFFFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } tx_fb_state_t;

  // Frame length after padding to the Ethernet minimum (excluding preamble/CRC).
  function automatic logic [9:0] pad_to_min(input logic [9:0] len);
    return (len < 10'(C_MIN_FRAME_BYTES)) ? 10'(C_MIN_FRAME_BYTES) : len;
  endfunction

endpackage

// File: rtl/tx_frame_builder.sv
// Assembles an Ethernet II frame (dst, src, type, payload, zero pad) into a flat vector for the MII TX FSM.
// Optional macro TX_FRAME_BUILDER_PAD_EN: report frames padded to the 60-byte minimum.
module tx_frame_builder
  import eth_pkg::*;
#(
  parameter logic [47:0] P_MAC_ADDR  = 48'h00183E02523A,
  parameter int          P_PKT_BITS  = 1500*8,
  parameter int          P_MAX_BYTES = 150
) (
  input  logic                  tx_clk,
  input  logic                  tx_rst,
  input  logic [47:0]           hdr_dst_mac,
  input  logic [15:0]           hdr_type,
  input  logic [7:0]            s_data,
  input  logic                  s_vld,
  input  logic                  s_last,
  output logic                  s_rdy,
  output logic [P_PKT_BITS-1:0] tx_pkt,
  output logic [9:0]            tx_byte_cnt,
  output logic                  tx_pkt_vld,
  input  logic                  tx_pkt_rdy,
  output logic                  drop_err
);

  localparam int PTR_W = $clog2(P_MAX_BYTES + 1);
  localparam logic [PTR_W-1:0] MAX_PTR   = PTR_W'(P_MAX_BYTES);
  localparam logic [PTR_W-1:0] FIRST_PTR = PTR_W'(C_HEADER_BYTES + 1);

  tx_fb_state_t     state_reg;
  logic [PTR_W-1:0] ptr_reg;
  logic             s_rdy_reg;
  logic             pkt_vld_reg;
  logic             drop_err_reg;
  logic [9:0]       byte_cnt_reg;

  logic                          accept;
  logic                          first_acc;
  logic                          fill_wr;
  logic [8*C_HEADER_BYTES-1:0]   hdr_vec;
  logic [9:0]                    last_len;
  logic [9:0]                    len_out;

  assign accept    = s_vld && s_rdy_reg;
  assign first_acc = accept && (state_reg == S_IDLE);
  assign fill_wr   = accept && (state_reg == S_FILL) && (ptr_reg != MAX_PTR);
  assign hdr_vec   = {hdr_dst_mac, P_MAC_ADDR, hdr_type};

  // Length including the byte being accepted now.
  assign last_len = (state_reg == S_IDLE) ? 10'(C_HEADER_BYTES + 1)
                                          : 10'(ptr_reg) + 10'd1;

`ifdef TX_FRAME_BUILDER_PAD_EN
  assign len_out = pad_to_min(last_len);
`else
  assign len_out = last_len;
`endif

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state_reg    <= S_IDLE;
      ptr_reg      <= '0;
      s_rdy_reg    <= 1'b0;
      pkt_vld_reg  <= 1'b0;
      drop_err_reg <= 1'b0;
      byte_cnt_reg <= '0;
    end else begin
      drop_err_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          s_rdy_reg <= 1'b1;
          if (accept) begin
            ptr_reg <= FIRST_PTR;
            if (s_last) begin
              state_reg    <= S_HOLD;
              pkt_vld_reg  <= 1'b1;
              byte_cnt_reg <= len_out;
              s_rdy_reg    <= 1'b0;
            end else begin
              state_reg <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (accept) begin
            if (ptr_reg == MAX_PTR) begin
              ptr_reg <= '0;
              if (s_last) begin
                drop_err_reg <= 1'b1;
                state_reg    <= S_IDLE;
              end else begin
                state_reg <= S_DROP;
              end
            end else begin
              ptr_reg <= ptr_reg + 1'b1;
              if (s_last) begin
                state_reg    <= S_HOLD;
                pkt_vld_reg  <= 1'b1;
                byte_cnt_reg <= len_out;
                s_rdy_reg    <= 1'b0;
              end
            end
          end
        end
        S_HOLD: begin
          if (tx_pkt_rdy) begin
            state_reg   <= S_IDLE;
            pkt_vld_reg <= 1'b0;
            s_rdy_reg   <= 1'b1;
            ptr_reg     <= '0;
          end
        end
        S_DROP: begin
          if (accept && s_last) begin
            drop_err_reg <= 1'b1;
            state_reg    <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // One register per frame byte; the first accept clears the frame and loads the header.
  for (genvar gi = 0; gi < P_MAX_BYTES; gi++) begin : g_byte
    logic [7:0] byte_reg;
    logic [7:0] init_byte;

    if (gi < C_HEADER_BYTES) begin : g_hdr
      assign init_byte = hdr_vec[8*(C_HEADER_BYTES-1-gi) +: 8];
    end else if (gi == C_HEADER_BYTES) begin : g_first
      assign init_byte = s_data;
    end else begin : g_pad
      assign init_byte = 8'h00;
    end

    always_ff @(posedge tx_clk) begin
      if (tx_rst) begin
        byte_reg <= '0;
      end else if (first_acc) begin
        byte_reg <= init_byte;
      end else if (fill_wr && (ptr_reg == PTR_W'(gi))) begin
        byte_reg <= s_data;
      end
    end

    assign tx_pkt[8*gi +: 8] = byte_reg;
  end

  if (P_PKT_BITS > 8*P_MAX_BYTES) begin : g_tail
    assign tx_pkt[P_PKT_BITS-1:8*P_MAX_BYTES] = '0;
  end

  assign s_rdy       = s_rdy_reg;
  assign tx_pkt_vld  = pkt_vld_reg;
  assign tx_byte_cnt = byte_cnt_reg;
  assign drop_err    = drop_err_reg;

endmodule

// File: tb/tb_tx_frame_builder.sv
// Directed, table-driven bench for tx_frame_builder (honours TX_FRAME_BUILDER_PAD_EN if defined).
module tb_tx_frame_builder;

  localparam int          PKT_BITS = 1500*8;
  localparam int          MAX_BYTES = 150;
  localparam logic [47:0] TB_MAC   = 48'h00183E02523A;
`ifdef TX_FRAME_BUILDER_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic                tx_clk = 1'b0;
  logic                tx_rst;
  logic [47:0]         hdr_dst_mac;
  logic [15:0]         hdr_type;
  logic [7:0]          s_data;
  logic                s_vld;
  logic                s_last;
  logic                s_rdy;
  logic [PKT_BITS-1:0] tx_pkt;
  logic [9:0]          tx_byte_cnt;
  logic                tx_pkt_vld;
  logic                tx_pkt_rdy;
  logic                drop_err;

  tx_frame_builder dut (
    .tx_clk      (tx_clk),
    .tx_rst      (tx_rst),
    .hdr_dst_mac (hdr_dst_mac),
    .hdr_type    (hdr_type),
    .s_data      (s_data),
    .s_vld       (s_vld),
    .s_last      (s_last),
    .s_rdy       (s_rdy),
    .tx_pkt      (tx_pkt),
    .tx_byte_cnt (tx_byte_cnt),
    .tx_pkt_vld  (tx_pkt_vld),
    .tx_pkt_rdy  (tx_pkt_rdy),
    .drop_err    (drop_err)
  );

  always #5 tx_clk = ~tx_clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int          len;
    logic [47:0] dst;
    logic [15:0] etype;
    logic [7:0]  base;
    int          exp_cnt;
    bit          exp_drop;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tx_clk);
    #1;
  endtask

  function automatic logic [7:0] pkt_byte(input int k);
    logic [7:0] b;
    b = tx_pkt[8*k +: 8];
    return b;
  endfunction

  function automatic logic [7:0] exp_byte(input int k, input int len, input logic [47:0] dst,
                                          input logic [15:0] et, input logic [7:0] base);
    if (k < 6)       return dst[47-8*k -: 8];
    if (k < 12)      return TB_MAC[47-8*(k-6) -: 8];
    if (k == 12)     return et[15:8];
    if (k == 13)     return et[7:0];
    if (k < 14+len)  return 8'(int'(base) + k - 14);
    return 8'h00;
  endfunction

  task automatic send_frame(input int len, input logic [47:0] dst, input logic [15:0] et,
                            input logic [7:0] base, output bit early_vld);
    int w;
    early_vld = 1'b0;
    for (int i = 0; i < len; i++) begin
      s_vld  = 1'b1;
      s_data = 8'(int'(base) + i);
      s_last = (i == len-1);
      // Headers must only be sampled with the first byte; corrupt them afterwards.
      hdr_dst_mac = (i == 0) ? dst : ~dst;
      hdr_type    = (i == 0) ? et  : ~et;
      w = 0;
      while (!s_rdy && w < 100) begin
        tick();
        w++;
      end
      if (w >= 100) begin
        check("s_rdy_timeout", 0, 1);
        s_vld = 1'b0;
        s_last = 1'b0;
        return;
      end
      if (tx_pkt_vld) early_vld = 1'b1;
      tick();
    end
    s_vld  = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic check_frame(input int len, input logic [47:0] dst, input logic [15:0] et,
                             input logic [7:0] base);
    int nbad;
    nbad = 0;
    for (int k = 0; k < MAX_BYTES; k++)
      if (pkt_byte(k) !== exp_byte(k, len, dst, et, base)) nbad++;
    check("frame_bytes_bad", nbad, 0);
    check("tail_zero", |tx_pkt[PKT_BITS-1:8*MAX_BYTES], 0);
  endtask

  task automatic take_frame();
    tx_pkt_rdy = 1'b1;
    tick();
    tx_pkt_rdy = 1'b0;
    check("vld_after_xfer", tx_pkt_vld, 0);
    check("s_rdy_after_xfer", s_rdy, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          early;
    int          nbad;
    logic [PKT_BITS-1:0] snap;

    vecs[0] = '{28,  48'hFFFFFFFFFFFF, 16'h0806, 8'h01, PAD ? 60 : 42,  1'b0};
    vecs[1] = '{100, 48'h0A0B0C0D0E0F, 16'h0800, 8'h20, 114,            1'b0};
    vecs[2] = '{136, 48'h112233445566, 16'h86DD, 8'h80, 150,            1'b0};
    vecs[3] = '{137, 48'h665544332211, 16'h0800, 8'h10, 0,              1'b1};
    vecs[4] = '{1,   48'h020000000001, 16'h88B5, 8'hA5, PAD ? 60 : 15,  1'b0};
    vecs[5] = '{46,  48'h0C0000000046, 16'h0800, 8'h33, 60,             1'b0};

    tx_rst = 1'b1; hdr_dst_mac = '0; hdr_type = '0; s_data = '0;
    s_vld = 1'b0; s_last = 1'b0; tx_pkt_rdy = 1'b0;
    repeat (3) tick();
    check("rst_s_rdy", s_rdy, 0);
    check("rst_vld", tx_pkt_vld, 0);
    check("rst_pkt_nonzero", |tx_pkt, 0);
    check("rst_cnt", tx_byte_cnt, 0);
    check("rst_drop", drop_err, 0);
    tx_rst = 1'b0;
    tick();
    check("s_rdy_after_rst", s_rdy, 1);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].len, vecs[v].dst, vecs[v].etype, vecs[v].base, early);
      check("early_vld", early, 0);
      if (vecs[v].exp_drop) begin
        check("drop_pulse", drop_err, 1);
        check("drop_no_vld", tx_pkt_vld, 0);
        tick();
        check("drop_one_cycle", drop_err, 0);
        check("drop_no_vld_later", tx_pkt_vld, 0);
        $display("vec %0d: len %0d dropped, drop_err seen", v, vecs[v].len);
      end else begin
        check("vld_latency", tx_pkt_vld, 1);
        check("byte_cnt", tx_byte_cnt, vecs[v].exp_cnt);
        check("no_drop", drop_err, 0);
        check_frame(vecs[v].len, vecs[v].dst, vecs[v].etype, vecs[v].base);
        if (v == 0) begin
          check("bc_b0", pkt_byte(0), 8'hFF);
          check("bc_b5", pkt_byte(5), 8'hFF);
          check("bc_b6", pkt_byte(6), 8'h00);
          check("bc_b7", pkt_byte(7), 8'h18);
          check("bc_b8", pkt_byte(8), 8'h3E);
          check("bc_b9", pkt_byte(9), 8'h02);
          check("bc_b10", pkt_byte(10), 8'h52);
          check("bc_b11", pkt_byte(11), 8'h3A);
          check("bc_b12", pkt_byte(12), 8'h08);
          check("bc_b13", pkt_byte(13), 8'h06);
          check("bc_b14", pkt_byte(14), 8'h01);
          check("bc_b41", pkt_byte(41), 8'h1C);
          nbad = 0;
          for (int k = 42; k < 60; k++) if (pkt_byte(k) != 8'h00) nbad++;
          check("bc_pad_nonzero", nbad, 0);
        end
        if (v == 4) check("short_b14", pkt_byte(14), 8'hA5);
        repeat (2) begin
          tick();
          check("vld_hold", tx_pkt_vld, 1);
          check("s_rdy_hold", s_rdy, 0);
        end
        $display("vec %0d: len %0d cnt %0d", v, vecs[v].len, tx_byte_cnt);
        take_frame();
      end
    end

    // Backpressure: a second frame is offered while the first is held.
    send_frame(20, 48'hA1A2A3A4A5A6, 16'h0800, 8'h40, early);
    check("bp_vld", tx_pkt_vld, 1);
    check("bp_cnt", tx_byte_cnt, PAD ? 60 : 34);
    snap = tx_pkt;
    s_vld = 1'b1; s_data = 8'h90; s_last = 1'b0;
    hdr_dst_mac = 48'hB1B2B3B4B5B6; hdr_type = 16'h86DD;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("bp_s_rdy", s_rdy, 0);
      check("bp_vld_held", tx_pkt_vld, 1);
      check("bp_pkt_changed", tx_pkt != snap, 0);
    end
    take_frame();
    send_frame(30, 48'hB1B2B3B4B5B6, 16'h86DD, 8'h90, early);
    check("bp2_vld", tx_pkt_vld, 1);
    check("bp2_cnt", tx_byte_cnt, PAD ? 60 : 44);
    check_frame(30, 48'hB1B2B3B4B5B6, 16'h86DD, 8'h90);
    $display("backpressure: second frame cnt %0d", tx_byte_cnt);
    take_frame();

    // Reset in the middle of a fill.
    for (int i = 0; i < 10; i++) begin
      s_vld = 1'b1; s_data = 8'(i); s_last = 1'b0;
      hdr_dst_mac = 48'h0E0E0E0E0E0E; hdr_type = 16'h0800;
      tick();
    end
    s_vld = 1'b0;
    tx_rst = 1'b1;
    tick();
    check("mid_rst_s_rdy", s_rdy, 0);
    check("mid_rst_vld", tx_pkt_vld, 0);
    check("mid_rst_pkt_nonzero", |tx_pkt, 0);
    check("mid_rst_cnt", tx_byte_cnt, 0);
    check("mid_rst_drop", drop_err, 0);
    tx_rst = 1'b0;
    nbad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (tx_pkt_vld || drop_err) nbad++;
    end
    check("post_rst_activity", nbad, 0);
    check("post_rst_s_rdy", s_rdy, 1);
    send_frame(5, 48'h123456789ABC, 16'h0800, 8'hC0, early);
    check("post_rst_vld", tx_pkt_vld, 1);
    check("post_rst_cnt", tx_byte_cnt, PAD ? 60 : 19);
    check_frame(5, 48'h123456789ABC, 16'h0800, 8'hC0);
    $display("reset mid-fill: recovery frame cnt %0d", tx_byte_cnt);
    take_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
